// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// The PAR state exists only when SEQ_TX_PARITY_EN is defined.
package seq_tx_pkg;

  localparam int unsigned PatWDefault   = 8;
  localparam int unsigned GapCycDefault = 2;
  localparam int unsigned RepW          = 4;

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StGap   = 2'b10,
    StPar   = 2'b11
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StGap   = 2'b10
  } state_e;
`endif

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register; exposes the current MSB and the bit behind it.
module seq_tx_shreg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             shift_en,
  output logic             msb,
  output logic             nxt
);

  logic [Width-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = {q_q[Width-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign msb = q_q[Width-1];
  assign nxt = q_q[Width-2];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern rep+1 times, separated by gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after each copy.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned PAT_W   = PatWDefault,
  parameter int unsigned GAP_CYC = GapCycDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [RepW-1:0]  rep_i,
  input  logic             abort_i,
  output logic             w_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(PAT_W);
  localparam logic [CntW-1:0] LastBit = CntW'(PAT_W - 1);
  localparam logic [3:0]      GapLast = 4'(GAP_CYC - 1);

  state_e state_q, state_d;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [RepW-1:0]  rep_q, rep_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             w_q, w_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             sh_load, sh_shift, sh_msb, sh_nxt;
  logic [PAT_W-1:0] sh_load_val;

  logic last_bit, gap_end, more_copies, copy_end;

  assign last_bit    = (bit_cnt_q == LastBit);
  assign gap_end     = (gap_cnt_q == GapLast);
  assign more_copies = (rep_q != '0);

`ifdef SEQ_TX_PARITY_EN
  assign copy_end = (state_q == StPar) && !abort_i;
`else
  assign copy_end = (state_q == StShift) && last_bit && !abort_i;
`endif

  seq_tx_shreg #(
    .Width (PAT_W)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift_en (sh_shift),
    .msb      (sh_msb),
    .nxt      (sh_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle: state_d = start_i ? StShift : StIdle;
      StShift: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (!last_bit) begin
          state_d = StShift;
        end else begin
`ifdef SEQ_TX_PARITY_EN
          state_d = StPar;
`else
          state_d = more_copies ? StGap : StIdle;
`endif
        end
      end
`ifdef SEQ_TX_PARITY_EN
      StPar: state_d = (!abort_i && more_copies) ? StGap : StIdle;
`endif
      StGap: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          state_d = gap_end ? StShift : StGap;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed one cycle ahead and registered, so w_o leads from a flop.
  always_comb begin
    pat_d       = pat_q;
    rep_d       = rep_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    w_d         = 1'b0;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_load_val = pat_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          pat_d       = pat_i;
          rep_d       = rep_i;
          sh_load     = 1'b1;
          sh_load_val = pat_i;
          bit_cnt_d   = '0;
          w_d         = pat_i[PAT_W-1];
          valid_d     = 1'b1;
        end
      end
      StShift: begin
        if (!abort_i) begin
          if (!last_bit) begin
            sh_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + CntW'(1);
            w_d       = sh_nxt;
            valid_d   = 1'b1;
          end
`ifdef SEQ_TX_PARITY_EN
          else begin
            w_d     = ^pat_q;
            valid_d = 1'b1;
          end
`endif
        end
      end
      StGap: begin
        if (!abort_i) begin
          if (gap_end) begin
            bit_cnt_d = '0;
            w_d       = sh_msb;
            valid_d   = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
      end
      default: ;
    endcase

    // The shift register is reloaded on entry to GAP and held there.
    if (copy_end) begin
      if (more_copies) begin
        rep_d     = rep_q - RepW'(1);
        sh_load   = 1'b1;
        gap_cnt_d = '0;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= '0;
      rep_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      w_q       <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      w_q       <= w_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign w_o     = w_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx (PAT_W=8, GAP_CYC=2); honours SEQ_TX_PARITY_EN.
module tb_seq_pattern_tx;

  localparam int PatW   = 8;
  localparam int GapCyc = 2;

  logic            clk;
  logic            rst_n;
  logic            start_i;
  logic [PatW-1:0] pat_i;
  logic [3:0]      rep_i;
  logic            abort_i;
  logic            w_o;
  logic            valid_o;
  logic            busy_o;
  logic            done_o;

  int n_tests = 0;
  int n_fail  = 0;

  seq_pattern_tx #(
    .PAT_W   (PatW),
    .GAP_CYC (GapCyc)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .pat_i   (pat_i),
    .rep_i   (rep_i),
    .abort_i (abort_i),
    .w_o     (w_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_start(input logic [7:0] pat, input logic [3:0] rep, input logic with_abort);
    start_i = 1'b1;
    pat_i   = pat;
    rep_i   = rep;
    abort_i = with_abort;
  endtask

  task automatic check_outs(input string tag, input logic w, input logic v, input logic b,
                            input logic d);
    check_eq($sformatf("%s w", tag), w_o, w);
    check_eq($sformatf("%s valid", tag), valid_o, v);
    check_eq($sformatf("%s busy", tag), busy_o, b);
    check_eq($sformatf("%s done", tag), done_o, d);
  endtask

  // Walks a whole frame from cycle 1; optionally pulses a stray start in inject_cyc
  // and optionally issues a new start during the done cycle.
  task automatic check_frame(input string name, input logic [7:0] pat, input int reps,
                             input int inject_cyc, input logic chain, input logic [7:0] chain_pat);
    int cyc = 0;
    for (int c = 0; c <= reps; c++) begin
      for (int k = 7; k >= 0; k--) begin
        step();
        cyc++;
        start_i = (cyc == inject_cyc);
        abort_i = 1'b0;
        if (cyc == inject_cyc) pat_i = 8'hFF;
        check_outs($sformatf("%s c%0d", name, cyc), pat[k], 1'b1, 1'b1, 1'b0);
      end
`ifdef SEQ_TX_PARITY_EN
      step();
      cyc++;
      start_i = (cyc == inject_cyc);
      check_outs($sformatf("%s par c%0d", name, cyc), ^pat, 1'b1, 1'b1, 1'b0);
`endif
      if (c < reps) begin
        for (int g = 0; g < GapCyc; g++) begin
          step();
          cyc++;
          start_i = (cyc == inject_cyc);
          check_outs($sformatf("%s gap c%0d", name, cyc), 1'b0, 1'b0, 1'b1, 1'b0);
        end
      end
    end
    step();
    cyc++;
    start_i = 1'b0;
    check_outs($sformatf("%s donecyc c%0d", name, cyc), 1'b0, 1'b0, 1'b0, 1'b1);
    if (chain) begin
      drive_start(chain_pat, 4'd0, 1'b0);
    end else begin
      step();
      check_eq($sformatf("%s done one-shot", name), done_o, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] p;
    rst_n   = 1'b0;
    start_i = 1'b0;
    pat_i   = '0;
    rep_i   = '0;
    abort_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Single copy, then two copies with a gap.
    drive_start(8'b1011_0011, 4'd0, 1'b0);
    check_frame("f1", 8'b1011_0011, 0, -1, 1'b0, 8'h00);
    drive_start(8'b1011_0011, 4'd1, 1'b0);
    check_frame("f2", 8'b1011_0011, 1, -1, 1'b0, 8'h00);

    // Stray start with 8'hFF in cycle 4 must be ignored.
    drive_start(8'b1011_0011, 4'd0, 1'b0);
    check_frame("f3", 8'b1011_0011, 0, 4, 1'b0, 8'h00);

    // Start with abort in IDLE is accepted; chained start in the done cycle.
    drive_start(8'b1011_0011, 4'd0, 1'b1);
    check_frame("b2b1", 8'b1011_0011, 0, -1, 1'b1, 8'h3C);
    check_frame("b2b2", 8'h3C, 0, -1, 1'b0, 8'h00);

    // Abort in cycle 5, restart in cycle 7.
    p = 8'b1011_0011;
    drive_start(p, 4'd0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      step();
      start_i = 1'b0;
      check_eq($sformatf("ab c%0d w", c), w_o, p[8-c]);
    end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_outs("ab c6", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("ab c7", 1'b0, 1'b0, 1'b0, 1'b0);
    drive_start(8'h96, 4'd0, 1'b0);
    check_frame("f4", 8'h96, 0, -1, 1'b0, 8'h00);

    // Reset asserted mid-frame in cycle 3.
    drive_start(8'b1011_0011, 4'd0, 1'b0);
    step();
    start_i = 1'b0;
    check_eq("rs c1 w", w_o, 1'b1);
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("rs async", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check_outs("rs held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    drive_start(8'b1011_0011, 4'd0, 1'b0);
    check_frame("f5", 8'b1011_0011, 0, -1, 1'b0, 8'h00);

    // Maximum repeat count: 16 copies.
    drive_start(8'h5A, 4'd15, 1'b0);
    check_frame("r15", 8'h5A, 15, -1, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter PAT_W, default 8: pattern length in bits, range 2..32.
REQ-002 Parameter GAP_CYC, default 2: low cycles between repeated copies, range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start_i  input  1  request to transmit; sampled only while busy_o=0.
REQ-006 pat_i  input  PAT_W  pattern to send, MSB first; captured with start_i.
REQ-007 rep_i  input  4  extra copies to send (total copies = rep_i+1); captured with start_i.
REQ-008 abort_i  input  1  terminate the transmission in progress.
REQ-009 w_o  output  1  registered serial stream, the w input of the downstream detector.
REQ-010 valid_o  output  1  high in each cycle w_o carries a pattern or parity bit.
REQ-011 busy_o  output  1  high from the cycle after acceptance until the final bit has been sent.
REQ-012 done_o  output  1  one-cycle pulse after a completed (non-aborted) transmission.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, PAR (only with the macro) and GAP; any illegal encoding SHALL go to IDLE.
REQ-014 IDLE: start_i=1 SHALL capture pat_i and rep_i into a shift register and a repeat counter, then move to SHIFT.
REQ-015 Latency: with start_i sampled at edge 0, w_o SHALL carry pat_i[PAT_W-1] in cycle 1 and bit k in cycle PAT_W-k.
REQ-016 SHIFT SHALL present one bit per cycle for exactly PAT_W cycles, tracked by a bit counter of width clog2(PAT_W).
REQ-017 After the last bit (or the parity bit): repeat counter >0 -> GAP, decrement the counter and reload the captured pattern; counter =0 -> IDLE with done_o=1 for one cycle.
REQ-018 GAP SHALL hold w_o=0 and valid_o=0 for exactly GAP_CYC cycles, then return to SHIFT.
REQ-019 w_o SHALL be 0 whenever valid_o=0.
REQ-020 A start_i while busy_o=1 SHALL be ignored, with no effect on the pattern or the counters.
REQ-021 start_i in the same cycle as the done_o pulse SHALL be accepted, giving back-to-back frames with no idle bit.
REQ-022 abort_i=1 in any non-IDLE state SHALL go to IDLE at the next edge, with w_o, valid_o and busy_o low in that cycle and no done_o.
REQ-023 If abort_i and start_i are both high in IDLE, the start SHALL be accepted.
REQ-024 rep_i=0 SHALL send exactly one copy; rep_i=15 SHALL send 16 copies.

Reset
REQ-025 rst_n low SHALL force IDLE at once and set w_o=0, valid_o=0, busy_o=0, done_o=0, and all counters and the shift register to 0.
REQ-026 Reset during SHIFT or GAP SHALL drop the frame; the first accepted start after release SHALL transmit normally.

Configuration
REQ-027 With macro SEQ_TX_PARITY_EN defined, each copy SHALL be followed by one PAR cycle where w_o is the even-parity bit (XOR of the pattern) and valid_o=1; GAP or done follows PAR.
REQ-028 With SEQ_TX_PARITY_EN undefined, the PAR state and its logic SHALL be absent, and the frame is PAT_W bits.

Structure
REQ-029 Package seq_tx_pkg SHALL hold the state enum typedef, the GAP_CYC and PAT_W defaults, and the repeat-counter width constant (4).
REQ-030 Sub-module seq_tx_shreg SHALL provide the loadable MSB-first shift register with parallel load and shift enable; the FSM and counters stay in the top level.

Verification
REQ-031 pat_i=8'b1011_0011, rep_i=0, start at edge 0 -> w_o = 1,0,1,1,0,0,1,1 in cycles 1-8 with valid_o=1; done_o=1 in cycle 9 only.
REQ-032 Same pattern, rep_i=1 -> copy 1 in cycles 1-8, w_o=0 and valid_o=0 in cycles 9-10, copy 2 in cycles 11-18; done_o in cycle 19.
REQ-033 start_i pulsed in cycle 4 with pat_i=8'hFF during REQ-031 -> stream unchanged, single done_o in cycle 9.
REQ-034 abort_i=1 in cycle 5 -> cycle 6 idle, w_o=0, busy_o=0, no done_o; a new start in cycle 7 sends a full frame.
REQ-035 rst_n low in cycle 3 -> outputs 0 immediately, FSM in IDLE; a restart after release matches REQ-031 timing.
REQ-036 SEQ_TX_PARITY_EN defined, pat_i=8'b0000_0111 -> parity bit w_o=1 in cycle 9 with valid_o=1; done_o in cycle 10.
